// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator sharing one frame counter; edge- or center-aligned frames,
// shadowed duty/period/mode that take effect only when the counter returns to zero.
module pwm_multichannel #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [NCH-1:0]   polarity,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_end
);

  // Count direction is the only state machine; it only leaves DIR_UP in center mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t             dir, dir_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] per_act;
  logic             mode_act;
  logic             frame_wrap;
  logic [WIDTH-1:0] duty_sh     [NCH];
  logic [WIDTH-1:0] duty_sh_nxt [NCH];
  logic [WIDTH-1:0] duty_act    [NCH];
  logic [NCH-1:0]   raw;

  // Next counter value; a frame boundary is any edge at which cnt lands on zero.
  // While disabled the counter is pinned at zero, so every edge reloads the active set.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (!enable) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!mode_act || per_act == '0) begin
      cnt_nxt = (cnt >= per_act) ? '0 : cnt + WIDTH'(1);
    end else if (dir == DIR_UP) begin
      if (cnt >= per_act) begin
        cnt_nxt = per_act - WIDTH'(1);
        dir_nxt = (per_act == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
        dir_nxt = DIR_UP;
      end
    end else begin
      cnt_nxt = cnt - WIDTH'(1);
      dir_nxt = (cnt == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
    end
    frame_wrap = (cnt_nxt == '0);
  end

  // Shadow next-values double as the forwarding path for writes landing on a boundary.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      duty_sh_nxt[i] = (wr_en && wr_ch == CW'(i)) ? wr_duty : duty_sh[i];
      raw[i]         = (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      per_act    <= '0;
      mode_act   <= 1'b0;
      period_end <= 1'b0;
      pwm_out    <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      period_end <= enable && frame_wrap;
      pwm_out    <= enable ? (raw ^ polarity) : polarity;
      for (int i = 0; i < NCH; i++) begin
        duty_sh[i] <= duty_sh_nxt[i];
      end
      if (frame_wrap) begin
        per_act  <= period;
        mode_act <= mode;
        for (int i = 0; i < NCH; i++) begin
          duty_act[i] <= duty_sh_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: frame lengths, per-channel high counts,
// shadow/forwarding timing, polarity, enable and asynchronous reset.
module tb_pwm_multichannel;

  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             wr_en;
  logic [CW-1:0]    wr_ch;
  logic [WIDTH-1:0] wr_duty;
  logic [NCH-1:0]   polarity;
  logic [NCH-1:0]   pwm_out;
  logic             period_end;

  int n_tests = 0;
  int n_fail  = 0;
  int hi [NCH];
  int pe_cnt;

  pwm_multichannel #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .period     (period),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .polarity   (polarity),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = ch[CW-1:0];
    wr_duty = d[WIDTH-1:0];
    step();
    wr_en   = 1'b0;
  endtask

  // Steps until period_end is seen and checks how many cycles that took.
  task automatic wait_pe(input string tag, input int exp_len);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!period_end && k < 200);
    check(tag, k, exp_len);
  endtask

  // Observes n cycles of output starting at cnt=0; optional one-shot write at offset wr_at.
  task automatic run_frame(input int n, input int wr_at, input int wch, input int wd);
    pe_cnt = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int j = 0; j < n; j++) begin
      if (j == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = wch[CW-1:0];
        wr_duty = wd[WIDTH-1:0];
      end
      step();
      wr_en = 1'b0;
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
      pe_cnt += int'(period_end);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 1'b0;
    period   = 8'd9;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_duty  = '0;
    polarity = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_pe", int'(period_end), 0);
    check("rst_cnt", int'(dut.cnt), 0);

    reset = 1'b0;
    write_duty(0, 3);
    write_duty(1, 0);
    write_duty(2, 2);
    check("dis_pwm", int'(pwm_out), 4);
    check("dis_cnt", int'(dut.cnt), 0);

    // Edge mode, P=9
    enable = 1'b1;
    wait_pe("first_len", 10);
    run_frame(10, -1, 0, 0);
    check("e_d3", hi[0], 3);
    check("e_d0", hi[1], 0);
    check("e_inv", hi[2], 8);
    check("e_pe", pe_cnt, 1);

    run_frame(10, 4, 0, 7);
    check("mid_keep", hi[0], 3);
    check("mid_pe", pe_cnt, 1);
    run_frame(10, 9, 0, 5);
    check("mid_next", hi[0], 7);
    run_frame(10, 2, 3, 0);
    check("bnd_fwd", hi[0], 5);

    // Period change mid-frame, plus mid-frame write of D1=255
    period = 8'd4;
    run_frame(10, 5, 1, 255);
    check("oor_ch0", hi[0], 5);
    check("oor_ch1", hi[1], 0);
    check("oor_ch2", hi[2], 8);
    check("p_keep_pe", pe_cnt, 1);
    run_frame(5, -1, 0, 0);
    check("p4_ch0", hi[0], 5);
    check("p4_d255", hi[1], 5);
    check("p4_ch2", hi[2], 3);
    check("p4_pe", pe_cnt, 1);

    // Center mode, P=4
    mode = 1'b1;
    run_frame(5, 0, 1, 2);
    check("pre_c_ch1", hi[1], 5);
    check("pre_c_pe", pe_cnt, 1);
    run_frame(8, 7, 1, 5);
    check("c_d2", hi[1], 3);
    check("c_d5gt", hi[0], 8);
    check("c_inv", hi[2], 5);
    check("c_pe", pe_cnt, 1);
    period = 8'd0;
    mode   = 1'b0;
    run_frame(8, -1, 0, 0);
    check("c_fwd_d5", hi[1], 8);
    check("c_pe2", pe_cnt, 1);

    // Period 0: one-cycle frames in both modes
    run_frame(4, -1, 0, 0);
    check("p0_pe", pe_cnt, 4);
    check("p0_ch0", hi[0], 4);
    check("p0_ch2", hi[2], 0);
    mode = 1'b1;
    run_frame(4, -1, 0, 0);
    check("p0c_pe", pe_cnt, 4);

    // Disable: outputs follow polarity live
    enable = 1'b0;
    step();
    step();
    check("dis2_pwm", int'(pwm_out), 4);
    check("dis2_cnt", int'(dut.cnt), 0);
    check("dis2_pe", int'(period_end), 0);
    polarity = 3'b011;
    step();
    check("live_pol", int'(pwm_out), 3);

    // Asynchronous reset mid-frame
    period = 8'd9;
    mode   = 1'b0;
    enable = 1'b1;
    repeat (5) step();
    write_duty(0, 9);
    reset = 1'b1;
    #1;
    check("arst_pwm", int'(pwm_out), 0);
    check("arst_pe", int'(period_end), 0);
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rel_cnt", int'(dut.cnt), 0);
    enable = 1'b1;
    wait_pe("restart_len", 10);
    run_frame(10, -1, 0, 0);
    check("lost_wr", hi[0], 10);
    check("rst_ch2", hi[2], 0);
    check("restart_pe", pe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
